// File: rtl/fixed_point_pkg.sv
// ============================================================================
// Module  : fixed_point_pkg
// Brief   : Shared sign-magnitude fixed-point constants and multiplier states.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fixed_point_pkg;

  localparam int DEFAULT_BITSIZE   = 16;
  localparam int DEFAULT_FRAC_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } mult_state_e;

endpackage

`default_nettype wire

// File: rtl/fixed_point_mult_norm.sv
// ============================================================================
// Module  : fixed_point_mult_norm
// Brief   : Combinational scale/round/saturate of an unsigned product into a
//           sign-magnitude word. Rounding enabled by FIXED_POINT_MULT_ROUND_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_point_mult_norm
  import fixed_point_pkg::*;
#(
  parameter int BITSIZE   = DEFAULT_BITSIZE,
  parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
  input  logic [2*(BITSIZE-1)-1:0] p,
  input  logic                     sign_in,
  output logic [BITSIZE-1:0]       c,
  output logic                     ovf
);

  localparam int MW = BITSIZE - 1;
  localparam int PW = 2 * MW;

`ifdef FIXED_POINT_MULT_ROUND_EN
  localparam logic [PW:0] C_RND = {{PW{1'b0}}, 1'b1} << (FRAC_BITS - 1);
`else
  localparam logic [PW:0] C_RND = '0;
`endif

  logic [PW:0]           sum;
  logic [PW-FRAC_BITS:0] scaled;
  logic [MW-1:0]         mag;
  logic                  unused_low;

  // One extra bit keeps a rounding carry out of the top from being lost.
  assign sum        = {1'b0, p} + C_RND;
  assign scaled     = sum[PW:FRAC_BITS];
  assign unused_low = ^sum[FRAC_BITS-1:0];

  assign ovf = |scaled[PW-FRAC_BITS:MW];
  assign mag = ovf ? {MW{1'b1}} : scaled[MW-1:0];
  assign c   = {sign_in & (|mag), mag};

endmodule

`default_nettype wire

// File: rtl/fixed_point_mult_seq.sv
// ============================================================================
// Module  : fixed_point_mult_seq
// Brief   : Sequential shift-add sign-magnitude fixed-point multiplier with
//           valid/ready handshake. Rounding enabled by FIXED_POINT_MULT_ROUND_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_point_mult_seq
  import fixed_point_pkg::*;
#(
  parameter int BITSIZE   = DEFAULT_BITSIZE,
  parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITSIZE-1:0] A,
  input  logic [BITSIZE-1:0] B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITSIZE-1:0] C,
  output logic               ovf
);

  localparam int MW = BITSIZE - 1;
  localparam int PW = 2 * MW;
  localparam int CW = (MW > 1) ? $clog2(MW) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(MW - 1);

  mult_state_e        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      mag_a_q, mag_a_d;
  logic [MW-1:0]      mag_b_q, mag_b_d;
  logic               sign_q, sign_d;
  logic [BITSIZE-1:0] c_q, c_d;
  logic               ovf_q, ovf_d;

  logic [BITSIZE-1:0] norm_c;
  logic               norm_ovf;

  fixed_point_mult_norm #(
    .BITSIZE   (BITSIZE),
    .FRAC_BITS (FRAC_BITS)
  ) u_norm (
    .p       (acc_q),
    .sign_in (sign_q),
    .c       (norm_c),
    .ovf     (norm_ovf)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    sign_d  = sign_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_CALC;
          mag_a_d = {{MW{1'b0}}, A[MW-1:0]};
          mag_b_d = B[MW-1:0];
          sign_d  = A[BITSIZE-1] ^ B[BITSIZE-1];
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        // Multiplicand shifts up and multiplier shifts down, so bit i always
        // meets magA<<i without a barrel shifter.
        if (mag_b_q[0]) begin
          acc_d = acc_q + mag_a_q;
        end
        mag_a_d = mag_a_q << 1;
        mag_b_d = mag_b_q >> 1;
        if (cnt_q == C_CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_NORM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_NORM: begin
        c_d     = norm_c;
        ovf_d   = norm_ovf;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      sign_q  <= 1'b0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      sign_q  <= sign_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign C         = c_q;
  assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_fixed_point_mult_seq.sv
// ============================================================================
// Module  : tb_fixed_point_mult_seq
// Brief   : Directed scoreboard bench for fixed_point_mult_seq (16-bit, 8 frac).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fixed_point_mult_seq;

  localparam int BS = 16;
  localparam int FB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BS-1:0] A = '0;
  logic [BS-1:0] B = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BS-1:0] C;
  logic          ovf;

  int checks = 0;
  int errors = 0;
  logic [BS:0] exp_q[$];

  fixed_point_mult_seq #(
    .BITSIZE   (BS),
    .FRAC_BITS (FB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product, optional half-up, shift, saturate.
  function automatic logic [BS:0] model(input logic [BS-1:0] a, input logic [BS-1:0] b);
    logic [31:0] p;
    logic [31:0] s;
    logic [14:0] mag;
    logic        ov;
    p = 32'(a[14:0]) * 32'(b[14:0]);
`ifdef FIXED_POINT_MULT_ROUND_EN
    p = p + 32'd128;
`endif
    s = p >> FB;
    if (s > 32'd32767) begin
      mag = 15'h7FFF;
      ov  = 1'b1;
    end else begin
      mag = s[14:0];
      ov  = 1'b0;
    end
    return {ov, (a[15] ^ b[15]) & (mag != 15'd0), mag};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; hold>0 keeps out_ready low that many cycles in DONE.
  task automatic do_op(input string tag, input logic [BS-1:0] a, input logic [BS-1:0] b,
                       input int hold);
    int n;
    int lat;
    logic [BS:0]   e;
    logic [BS-1:0] c_seen;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_ready_before"}, 32'(in_ready), 32'd1);
    A = a;
    B = b;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    exp_q.push_back(model(a, b));
    step();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(BS));
    e = exp_q.pop_front();
    chk({tag, "_C"}, 32'(C), 32'(e[BS-1:0]));
    chk({tag, "_ovf"}, 32'(ovf), 32'(e[BS]));
    c_seen = C;
    for (int i = 0; i < hold; i++) begin
      A = BS'($urandom);
      B = BS'($urandom);
      in_valid = 1'b1;
      step();
      chk({tag, "_bp_C"}, 32'(C), 32'(e[BS-1:0]));
      chk({tag, "_bp_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_bp_out_valid"}, 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk({tag, "_done_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_done_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_held_C"}, 32'(C), 32'(c_seen));
    if (hold > 0) begin
      step();
      chk({tag, "_no_capture"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [BS-1:0] ra;
    logic [BS-1:0] rb;

    repeat (3) step();
    chk("rst_C", 32'(C), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    do_op("basic", 16'h0180, 16'h0200, 0);
    chk("basic_const", 32'(C), 32'h0300);
    do_op("neg", 16'h8180, 16'h0200, 0);
    chk("neg_const", 32'(C), 32'h8300);
    do_op("negneg", 16'h8180, 16'h8200, 0);
    chk("negneg_const", 32'(C), 32'h0300);
    do_op("negzero", 16'h8000, 16'h0100, 0);
    chk("negzero_const", 32'(C), 32'h0000);
    do_op("round", 16'h0001, 16'h0080, 0);
`ifdef FIXED_POINT_MULT_ROUND_EN
    chk("round_const", 32'(C), 32'h0001);
`else
    chk("round_const", 32'(C), 32'h0000);
`endif
    do_op("bp", 16'h0340, 16'h8123, 5);
    for (int i = 0; i < 4; i++) begin
      ra = BS'($urandom);
      rb = BS'($urandom_range(0, 16'h0400)) | (BS'($urandom_range(0, 1)) << 15);
      do_op("rand", ra, rb, 0);
    end
    do_op("sat", 16'h7F00, 16'h0200, 0);
    chk("sat_const", 32'({ovf, C}), 32'h17FFF);

    // Abort an operation after seven CALC iterations.
    A = 16'h0180;
    B = 16'h0200;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    chk("abort_C", 32'(C), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    do_op("after_abort", 16'h0100, 16'h0100, 0);
    chk("after_abort_const", 32'(C), 32'h0100);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
